// File: rtl/ar_id_remap_unit_if.sv
// AXI AR-channel bundle shared by the master side and the request-buffer side
// of the ID remapper.
interface ar_if #(
    parameter int ID_WIDTH    = 4,
    parameter int ADDR_WIDTH  = 32,
    parameter int LEN_WIDTH   = 8,
    parameter int SIZE_WIDTH  = 3,
    parameter int BURST_WIDTH = 2,
    parameter int QOS_WIDTH   = 4
);
    logic [ID_WIDTH-1:0]    id;
    logic [ADDR_WIDTH-1:0]  addr;
    logic [LEN_WIDTH-1:0]   len;
    logic [SIZE_WIDTH-1:0]  size;
    logic [BURST_WIDTH-1:0] burst;
    logic [QOS_WIDTH-1:0]   qos;
    logic                   valid;
    logic                   ready;

    modport sender   (output id, addr, len, size, burst, qos, valid, input ready);
    modport receiver (input id, addr, len, size, burst, qos, valid, output ready);
endinterface

// File: rtl/ar_id_remap_unit.sv
// AR-channel ID remapper: maps master ARIDs onto compact UIDs with per-UID
// outstanding counts. Optional statistics counters: define AR_REMAP_STATS_EN.
module ar_id_remap_unit #(
    parameter int ID_WIDTH    = 4,
    parameter int UID_WIDTH   = 2,
    parameter int MAX_OUT     = 4,
    parameter int ADDR_WIDTH  = 32,
    parameter int LEN_WIDTH   = 8,
    parameter int SIZE_WIDTH  = 3,
    parameter int BURST_WIDTH = 2,
    parameter int QOS_WIDTH   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ar_if.receiver               ar_in,
    ar_if.sender                 ar_out,
    input  logic                 Outcoming_buffer_full,
    input  logic                 rel_valid,
    input  logic [UID_WIDTH-1:0] rel_uid,
    input  logic [UID_WIDTH-1:0] lkp_uid,
    output logic [ID_WIDTH-1:0]  lkp_orig_id,
    output logic                 lkp_valid,
    output logic                 rel_err
`ifdef AR_REMAP_STATS_EN
    ,
    output logic [31:0]          stat_accepts,
    output logic [31:0]          stat_stall_table,
    output logic [31:0]          stat_stall_bp
`endif
);
    localparam int NUM_UIDS = 2 ** UID_WIDTH;
    localparam int CNT_W    = $clog2(MAX_OUT + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);

    logic [NUM_UIDS-1:0] r_used;
    logic [ID_WIDTH-1:0] r_orig_id [NUM_UIDS];
    logic [CNT_W-1:0]    r_cnt     [NUM_UIDS];
    logic                r_rel_err;

    logic                   r_oreg_valid;
    logic [ID_WIDTH-1:0]    r_id;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [LEN_WIDTH-1:0]   r_len;
    logic [SIZE_WIDTH-1:0]  r_size;
    logic [BURST_WIDTH-1:0] r_burst;
    logic [QOS_WIDTH-1:0]   r_qos;

    logic                 w_hit;
    logic [UID_WIDTH-1:0] w_hit_idx;
    logic                 w_any_free;
    logic [UID_WIDTH-1:0] w_free_idx;
    logic                 w_alloc_ok;
    logic                 w_ready;
    logic                 w_accept;
    logic [UID_WIDTH-1:0] w_uid;
    logic [NUM_UIDS-1:0]  w_inc;
    logic [NUM_UIDS-1:0]  w_dec;

    // Descending scan so the last assignment wins: lowest free index.
    always_comb begin
        w_hit      = 1'b0;
        w_hit_idx  = '0;
        w_any_free = 1'b0;
        w_free_idx = '0;
        for (int i = NUM_UIDS - 1; i >= 0; i--) begin
            if (r_used[i] && (r_orig_id[i] == ar_in.id)) begin
                w_hit     = 1'b1;
                w_hit_idx = UID_WIDTH'(i);
            end
            if (!r_used[i]) begin
                w_any_free = 1'b1;
                w_free_idx = UID_WIDTH'(i);
            end
        end
    end

    // A saturated hit stalls rather than spilling into a second UID.
    assign w_alloc_ok = w_hit ? (r_cnt[w_hit_idx] < MAX_CNT) : w_any_free;
    assign w_ready    = (~r_oreg_valid | ar_out.ready) & w_alloc_ok & ~Outcoming_buffer_full;
    assign w_accept   = ar_in.valid & w_ready;
    assign w_uid      = w_hit ? w_hit_idx : w_free_idx;
    assign ar_in.ready = w_ready;

    always_comb begin
        w_inc = '0;
        w_dec = '0;
        if (w_accept)
            w_inc[w_uid] = 1'b1;
        if (rel_valid && (r_cnt[rel_uid] != '0))
            w_dec[rel_uid] = 1'b1;
    end

    // Simultaneous inc and dec on one entry cancel; used then stays set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_used    <= '0;
            r_rel_err <= 1'b0;
            for (int k = 0; k < NUM_UIDS; k++)
                r_cnt[k] <= '0;
        end else begin
            if (rel_valid && (r_cnt[rel_uid] == '0))
                r_rel_err <= 1'b1;
            for (int k = 0; k < NUM_UIDS; k++) begin
                if (w_inc[k] && !w_dec[k]) begin
                    r_used[k] <= 1'b1;
                    r_cnt[k]  <= r_cnt[k] + CNT_W'(1);
                end else if (!w_inc[k] && w_dec[k]) begin
                    r_cnt[k] <= r_cnt[k] - CNT_W'(1);
                    if (r_cnt[k] == CNT_W'(1))
                        r_used[k] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept && !w_hit)
            r_orig_id[w_free_idx] <= ar_in.id;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_oreg_valid <= 1'b0;
        else if (w_accept)
            r_oreg_valid <= 1'b1;
        else if (ar_out.ready)
            r_oreg_valid <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_id    <= ID_WIDTH'(w_uid);
            r_addr  <= ar_in.addr;
            r_len   <= ar_in.len;
            r_size  <= ar_in.size;
            r_burst <= ar_in.burst;
            r_qos   <= ar_in.qos;
        end
    end

    assign ar_out.valid = r_oreg_valid;
    assign ar_out.id    = r_id;
    assign ar_out.addr  = r_addr;
    assign ar_out.len   = r_len;
    assign ar_out.size  = r_size;
    assign ar_out.burst = r_burst;
    assign ar_out.qos   = r_qos;

    assign lkp_orig_id = r_orig_id[lkp_uid];
    assign lkp_valid   = r_used[lkp_uid];
    assign rel_err     = r_rel_err;

`ifdef AR_REMAP_STATS_EN
    logic [31:0] r_stat_acc;
    logic [31:0] r_stat_tbl;
    logic [31:0] r_stat_bp;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_acc <= '0;
            r_stat_tbl <= '0;
            r_stat_bp  <= '0;
        end else begin
            if (w_accept)
                r_stat_acc <= sat_inc(r_stat_acc);
            if (ar_in.valid && !w_alloc_ok)
                r_stat_tbl <= sat_inc(r_stat_tbl);
            if (ar_in.valid && w_alloc_ok && !w_ready)
                r_stat_bp <= sat_inc(r_stat_bp);
        end
    end

    assign stat_accepts     = r_stat_acc;
    assign stat_stall_table = r_stat_tbl;
    assign stat_stall_bp    = r_stat_bp;
`endif
endmodule

// File: tb/tb_ar_id_remap_unit.sv
// Self-checking bench for ar_id_remap_unit: directed scenarios plus a random
// stream, all compared against a table-level reference model.
module tb_ar_id_remap_unit;
    localparam int NU   = 4;
    localparam int MAXO = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ar_if u_in ();
    ar_if u_out ();

    logic       full;
    logic       rel_valid;
    logic [1:0] rel_uid;
    logic [1:0] lkp_uid;
    logic [3:0] lkp_orig_id;
    logic       lkp_valid;
    logic       rel_err;
`ifdef AR_REMAP_STATS_EN
    logic [31:0] s_acc, s_tbl, s_bp;
`endif

    ar_id_remap_unit dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .ar_in                 (u_in),
        .ar_out                (u_out),
        .Outcoming_buffer_full (full),
        .rel_valid             (rel_valid),
        .rel_uid               (rel_uid),
        .lkp_uid               (lkp_uid),
        .lkp_orig_id           (lkp_orig_id),
        .lkp_valid             (lkp_valid),
        .rel_err               (rel_err)
`ifdef AR_REMAP_STATS_EN
        ,
        .stat_accepts          (s_acc),
        .stat_stall_table      (s_tbl),
        .stat_stall_bp         (s_bp)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a table of (in use, original id, outstanding count)
    bit         m_used [NU];
    logic [3:0] m_id   [NU];
    int         m_cnt  [NU];
    bit         m_err;
    bit         m_ov;
    logic [3:0] m_oid;
    logic [31:0] m_oaddr;
    logic [7:0] m_olen;
    logic [2:0] m_osize;
    logic [1:0] m_oburst;
    logic [3:0] m_oqos;
    bit         last_acc;
    int         last_uid;
    bit         rand_lkp = 1'b1;

    function automatic int find_hit(input logic [3:0] id);
        for (int i = 0; i < NU; i++)
            if (m_used[i] && m_id[i] == id) return i;
        return -1;
    endfunction

    function automatic int find_free();
        for (int i = 0; i < NU; i++)
            if (!m_used[i]) return i;
        return -1;
    endfunction

    function automatic bit model_ok(input logic [3:0] id);
        int h;
        h = find_hit(id);
        if (h >= 0) return m_cnt[h] < MAXO;
        return find_free() >= 0;
    endfunction

    task automatic set_ar(input bit v, input logic [3:0] id);
        u_in.valid = v;
        u_in.id    = id;
        u_in.addr  = $urandom;
        u_in.len   = 8'($urandom);
        u_in.size  = 3'($urandom);
        u_in.burst = 2'($urandom);
        u_in.qos   = 4'($urandom);
    endtask

    // One clock: inputs are already driven at the negedge that starts it.
    task automatic tick();
        bit exp_rdy, acc, dec;
        int uid;
        uid = -1;
        if (rand_lkp) lkp_uid = 2'($urandom_range(0, 3));
        #1;
        exp_rdy = (!m_ov || u_out.ready) && model_ok(u_in.id) && !full;
        n_checks++;
        if (u_in.ready !== exp_rdy) begin
            n_fail++;
            $display("FAIL ar_in_ready t=%0t got %b want %b", $time, u_in.ready, exp_rdy);
        end
        n_checks++;
        if (lkp_valid !== m_used[lkp_uid] || (m_used[lkp_uid] && lkp_orig_id !== m_id[lkp_uid])) begin
            n_fail++;
            $display("FAIL lookup uid=%0d got v=%b id=%0d want v=%b id=%0d", lkp_uid,
                     lkp_valid, lkp_orig_id, m_used[lkp_uid], m_id[lkp_uid]);
        end
        acc = u_in.valid && exp_rdy;
        @(posedge clk);
        if (acc) begin
            uid = find_hit(u_in.id);
            if (uid < 0) uid = find_free();
        end
        dec = 1'b0;
        if (rel_valid) begin
            if (m_cnt[rel_uid] == 0) m_err = 1'b1;
            else dec = 1'b1;
        end
        if (acc) begin
            m_used[uid] = 1'b1;
            m_id[uid]   = u_in.id;
            m_cnt[uid]++;
        end
        if (dec) begin
            m_cnt[rel_uid]--;
            if (m_cnt[rel_uid] == 0) m_used[rel_uid] = 1'b0;
        end
        if (acc) begin
            m_ov     = 1'b1;
            m_oid    = 4'(uid);
            m_oaddr  = u_in.addr;
            m_olen   = u_in.len;
            m_osize  = u_in.size;
            m_oburst = u_in.burst;
            m_oqos   = u_in.qos;
        end else if (u_out.ready) begin
            m_ov = 1'b0;
        end
        last_acc = acc;
        last_uid = uid;
        @(negedge clk);
        n_checks++;
        if (u_out.valid !== m_ov) begin
            n_fail++;
            $display("FAIL ar_out_valid t=%0t got %b want %b", $time, u_out.valid, m_ov);
        end
        if (m_ov) begin
            n_checks++;
            if ({u_out.id, u_out.addr, u_out.len, u_out.size, u_out.burst, u_out.qos} !==
                {m_oid, m_oaddr, m_olen, m_osize, m_oburst, m_oqos}) begin
                n_fail++;
                $display("FAIL ar_out_payload got id=%0d addr=%h len=%0d want id=%0d addr=%h len=%0d",
                         u_out.id, u_out.addr, u_out.len, m_oid, m_oaddr, m_olen);
            end
        end
        n_checks++;
        if (rel_err !== m_err) begin
            n_fail++;
            $display("FAIL rel_err got %b want %b", rel_err, m_err);
        end
    endtask

    task automatic idle_inputs();
        set_ar(1'b0, 4'd0);
        u_out.ready = 1'b1;
        full        = 1'b0;
        rel_valid   = 1'b0;
        rel_uid     = 2'd0;
        lkp_uid     = 2'd0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        for (int i = 0; i < NU; i++) begin
            m_used[i] = 1'b0;
            m_cnt[i]  = 0;
            m_id[i]   = 4'd0;
        end
        m_err = 1'b0;
        m_ov  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        @(negedge clk);
        n_checks++;
        if (u_out.valid !== 1'b0 || rel_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs got valid=%b err=%b want 0 0", u_out.valid, rel_err);
        end
        for (int i = 0; i < NU; i++) begin
            lkp_uid = 2'(i);
            #1;
            n_checks++;
            if (lkp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_lkp_valid uid=%0d got %b want 0", i, lkp_valid);
            end
        end
        do_reset();
        tick();
    endtask

    task automatic test_single();
        do_reset();
        set_ar(1'b1, 4'd5);
        tick();
        set_ar(1'b0, 4'd0);
        lkp_uid = 2'd0;
        #1;
        n_checks++;
        if (u_out.valid !== 1'b1 || u_out.id !== 4'd0 || lkp_orig_id !== 4'd5 || lkp_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL single got v=%b id=%0d lkp=%0d/%b want 1 0 5/1",
                     u_out.valid, u_out.id, lkp_orig_id, lkp_valid);
        end
        @(negedge clk);
        tick();
    endtask

    task automatic test_fill_and_stall();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_ar(1'b1, 4'(i + 1));
            tick();
            n_checks++;
            if (u_out.id !== 4'(i) || !last_acc) begin
                n_fail++;
                $display("FAIL fill_uid arid=%0d got %0d want %0d", i + 1, u_out.id, i);
            end
        end
        set_ar(1'b1, 4'd7);
        repeat (3) tick();
        rel_valid = 1'b1;
        rel_uid   = 2'd2;
        tick();
        n_checks++;
        if (last_acc) begin
            n_fail++;
            $display("FAIL release_same_cycle got accept=1 want 0");
        end
        rel_valid = 1'b0;
        tick();
        n_checks++;
        if (u_out.valid !== 1'b1 || u_out.id !== 4'd2) begin
            n_fail++;
            $display("FAIL reuse_uid got v=%b id=%0d want 1 2", u_out.valid, u_out.id);
        end
        set_ar(1'b0, 4'd0);
        tick();
    endtask

    task automatic test_same_id();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_ar(1'b1, 4'd9);
            tick();
            n_checks++;
            if (u_out.id !== 4'd0 || !last_acc) begin
                n_fail++;
                $display("FAIL same_id_uid n=%0d got %0d acc=%b want 0 1", i, u_out.id, last_acc);
            end
        end
        tick();
        n_checks++;
        if (last_acc || u_in.ready !== 1'b0) begin
            n_fail++;
            $display("FAIL same_id_stall got acc=%b rdy=%b want 0 0", last_acc, u_in.ready);
        end
        rel_valid = 1'b1;
        rel_uid   = 2'd0;
        tick();
        rel_valid = 1'b0;
        tick();
        n_checks++;
        if (!last_acc || u_out.id !== 4'd0) begin
            n_fail++;
            $display("FAIL same_id_resume got acc=%b id=%0d want 1 0", last_acc, u_out.id);
        end
        set_ar(1'b0, 4'd0);
        tick();
    endtask

    task automatic test_backpressure();
        logic [31:0] h_addr;
        logic [3:0]  h_id;
        do_reset();
        u_out.ready = 1'b0;
        set_ar(1'b1, 4'd3);
        tick();
        h_addr = m_oaddr;
        h_id   = m_oid;
        set_ar(1'b1, 4'd8);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (u_out.addr !== h_addr || u_out.id !== h_id || u_in.ready !== 1'b0 || last_acc) begin
                n_fail++;
                $display("FAIL hold_stable cyc=%0d got addr=%h id=%0d want %h %0d",
                         i, u_out.addr, u_out.id, h_addr, h_id);
            end
        end
        u_out.ready = 1'b1;
        tick();
        n_checks++;
        if (!last_acc || u_out.id !== 4'd1) begin
            n_fail++;
            $display("FAIL bp_resume got acc=%b id=%0d want 1 1", last_acc, u_out.id);
        end
        set_ar(1'b0, 4'd0);
        tick();
    endtask

    task automatic test_hit_release();
        do_reset();
        set_ar(1'b1, 4'd2);
        tick();
        set_ar(1'b1, 4'd6);
        tick();
        rel_valid = 1'b1;
        rel_uid   = 2'd1;
        tick();
        rel_valid = 1'b0;
        set_ar(1'b0, 4'd0);
        rand_lkp = 1'b0;
        lkp_uid  = 2'd1;
        tick();
        n_checks++;
        if (lkp_valid !== 1'b1 || lkp_orig_id !== 4'd6) begin
            n_fail++;
            $display("FAIL hit_release_keep got v=%b id=%0d want 1 6", lkp_valid, lkp_orig_id);
        end
        rel_valid = 1'b1;
        tick();
        rel_valid = 1'b0;
        #1;
        n_checks++;
        if (lkp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL hit_release_cnt got v=%b want 0", lkp_valid);
        end
        rand_lkp = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_rel_err_and_full();
        do_reset();
        set_ar(1'b1, 4'd4);
        tick();
        set_ar(1'b0, 4'd0);
        rel_valid = 1'b1;
        rel_uid   = 2'd3;
        tick();
        rel_valid = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (rel_err !== 1'b1) begin
            n_fail++;
            $display("FAIL rel_err_sticky got %b want 1", rel_err);
        end
        full = 1'b1;
        set_ar(1'b1, 4'd4);
        tick();
        set_ar(1'b1, 4'd11);
        tick();
        n_checks++;
        if (u_in.ready !== 1'b0 || last_acc) begin
            n_fail++;
            $display("FAIL buffer_full got rdy=%b want 0", u_in.ready);
        end
        full = 1'b0;
        tick();
        set_ar(1'b0, 4'd0);
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        u_out.ready = 1'b0;
        set_ar(1'b1, 4'd12);
        tick();
        set_ar(1'b0, 4'd0);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (u_out.valid !== 1'b0 || lkp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset got valid=%b lkp=%b want 0 0", u_out.valid, lkp_valid);
        end
        do_reset();
        u_out.ready = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            set_ar($urandom_range(0, 3) != 0, 4'($urandom_range(0, 6)));
            u_out.ready = $urandom_range(0, 3) != 0;
            full        = $urandom_range(0, 9) == 0;
            rel_valid   = $urandom_range(0, 9) < 4;
            rel_uid     = 2'($urandom_range(0, 3));
            tick();
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_and_stall();
        test_same_id();
        test_backpressure();
        test_hit_release();
        test_rel_err_and_full();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
